elevador_call_queue: RTL

- Upstream request stage for the elevator controller. It synchronises and debounces the raw floor call buttons, latches them as pending calls, and picks the next target floor with direction-priority (SCAN) scheduling.
- It offers one target at a time to the controller over a valid/ready handshake. It clears a call when the controller reports arrival at that floor.
- The pending vector also drives the call lamps.

---
 rtl/elevador_pkg.sv | 20 ++
 rtl/call_debounce.sv | 48 ++++
 rtl/elevador_call_queue.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/elevador_pkg.sv
// Shared types and defaults for the elevator call-queue slice:
// FSM state encoding, default sizing and the floor-index type.
package elevador_pkg;

   localparam int NUM_FLOORS_DEF      = 4;
   localparam int DEBOUNCE_CYCLES_DEF = 16;

   // Wide enough for the largest supported building (8 floors).
   localparam int FW_MAX   = 3;
   localparam int DB_CNT_W = 8;

   typedef logic [FW_MAX-1:0] floor_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OFFER = 2'd1,
      BUSY  = 2'd2
   } fsm_state_t;

endpackage

// File: rtl/call_debounce.sv
// One call button: 2-flop synchroniser, stability counter and debounced
// level; emits a single-cycle pulse when the debounced level rises.
module call_debounce
   import elevador_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic rise
);

   localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic                sync1_reg;
   logic                sync2_reg;
   logic                db_reg;
   logic                rise_reg;
   logic [DB_CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         db_reg    <= 1'b0;
         rise_reg  <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         sync1_reg <= raw;
         sync2_reg <= sync1_reg;
         rise_reg  <= 1'b0;
         if (sync2_reg == db_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CNT_LAST) begin
            // Stable long enough: accept the new level, pulse only on a press.
            db_reg   <= sync2_reg;
            cnt_reg  <= '0;
            rise_reg <= sync2_reg;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign rise = rise_reg;

endmodule

// File: rtl/elevador_call_queue.sv
// Latches debounced floor calls and offers the next target over valid/ready
// using SCAN ordering; clears a call when the car reports service there.
module elevador_call_queue
   import elevador_pkg::*;
#(
   parameter  int NUM_FLOORS      = NUM_FLOORS_DEF,
   parameter  int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   localparam int FW              = $clog2(NUM_FLOORS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_FLOORS-1:0] boton,
   input  logic [FW-1:0]         cur_floor,
   input  logic                  at_floor,
   input  logic                  req_ready,
   output logic                  req_valid,
   output logic [FW-1:0]         req_floor,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  dir_up
);

   fsm_state_t            state_reg;
   logic                  req_valid_reg;
   logic [FW-1:0]         req_floor_reg;
   logic [NUM_FLOORS-1:0] pending_reg;
   logic                  dir_up_reg;

   logic [NUM_FLOORS-1:0] rise_vec;

   generate
      for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_btn
         call_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_debounce (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (boton[gi]),
            .rise (rise_vec[gi])
         );
      end
   endgenerate

   logic                  cur_ok;
   logic [NUM_FLOORS-1:0] masked;
   logic                  up_found;
   logic                  dn_found;
   logic [FW-1:0]         up_idx;
   logic [FW-1:0]         dn_idx;
   logic                  sel_found;
   logic [FW-1:0]         sel_floor;
   logic                  sel_dir_up;

   always_comb begin
      cur_ok = ({1'b0, cur_floor} < (FW+1)'(NUM_FLOORS));
      masked = pending_reg;
      if (cur_ok) begin
         masked[cur_floor] = 1'b0;
      end
      up_found = 1'b0;
      up_idx   = '0;
      dn_found = 1'b0;
      dn_idx   = '0;
      // Scan downward so the last hit is the lowest floor above the car.
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         if (masked[i] && (i > int'(cur_floor))) begin
            up_found = 1'b1;
            up_idx   = FW'(i);
         end
      end
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (masked[i] && (i < int'(cur_floor))) begin
            dn_found = 1'b1;
            dn_idx   = FW'(i);
         end
      end
      if (!cur_ok) begin
         up_found = 1'b0;
         dn_found = 1'b0;
      end
      sel_found  = up_found | dn_found;
      sel_floor  = '0;
      sel_dir_up = dir_up_reg;
      if (dir_up_reg) begin
         if (up_found) begin
            sel_floor  = up_idx;
            sel_dir_up = 1'b1;
         end else begin
            sel_floor  = dn_idx;
            sel_dir_up = 1'b0;
         end
      end else begin
         if (dn_found) begin
            sel_floor  = dn_idx;
            sel_dir_up = 1'b0;
         end else begin
            sel_floor  = up_idx;
            sel_dir_up = 1'b1;
         end
      end
   end

   logic                  here_clear;
   logic                  arrive;
   logic [NUM_FLOORS-1:0] clr_vec;

   always_comb begin
      here_clear = (state_reg == IDLE) && at_floor && cur_ok && pending_reg[cur_floor];
      arrive     = (state_reg == BUSY) && at_floor && (cur_floor == req_floor_reg);
      clr_vec    = '0;
      if (here_clear) begin
         clr_vec[cur_floor] = 1'b1;
      end
      if (arrive) begin
         clr_vec[req_floor_reg] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         req_valid_reg <= 1'b0;
         req_floor_reg <= '0;
         pending_reg   <= '0;
         dir_up_reg    <= 1'b1;
      end else begin
         // Clear beats a same-edge press; the button edge is already spent.
         pending_reg <= (pending_reg | rise_vec) & ~clr_vec;
         case (state_reg)
            IDLE: begin
               if (!here_clear && sel_found) begin
                  req_floor_reg <= sel_floor;
                  req_valid_reg <= 1'b1;
                  dir_up_reg    <= sel_dir_up;
                  state_reg     <= OFFER;
               end
            end
            OFFER: begin
               if (req_ready) begin
                  req_valid_reg <= 1'b0;
                  state_reg     <= BUSY;
               end
            end
            BUSY: begin
               if (arrive) begin
                  state_reg <= IDLE;
               end
            end
            default: begin
               req_valid_reg <= 1'b0;
               state_reg     <= IDLE;
            end
         endcase
      end
   end

   assign req_valid = req_valid_reg;
   assign req_floor = req_floor_reg;
   assign pending   = pending_reg;
   assign dir_up    = dir_up_reg;

endmodule
